// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and packing helper for the 10x10 matrix multiplier.
package matmul_pkg;

  localparam int N      = 10;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  typedef enum logic {
    COMPUTE = 1'b0,
    DONE    = 1'b1
  } state_t;

  // Bit offset of element (i,j) in a row-major flattened matrix bus.
  function automatic int elem_idx(input int i, input int j);
    return (i * N + j) * DATA_W;
  endfunction

endpackage

// File: rtl/dot_product_10.sv
// One output column: 10-term unsigned dot product of an A row and a B column.
// Build with SATURATE_EN defined to clamp the element at 255 instead of wrapping.
module dot_product_10
  import matmul_pkg::*;
(
  input  logic [N*DATA_W-1:0] a_row,
  input  logic [N*DATA_W-1:0] b_col,
  output logic [ACC_W-1:0]    sum,
  output logic [DATA_W-1:0]   elem
);

  function automatic logic [DATA_W-1:0] fit_elem(input logic [ACC_W-1:0] acc);
`ifdef SATURATE_EN
    logic [ACC_W-1:0] max_elem;
    max_elem = ACC_W'((1 << DATA_W) - 1);
    return (acc > max_elem) ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
`else
    return acc[DATA_W-1:0];
`endif
  endfunction

  // ACC_W leaves room for ten full-scale products, so the sum never overflows.
  always_comb begin
    logic [2*DATA_W-1:0] prod;
    prod = '0;
    sum  = '0;
    for (int k = 0; k < N; k++) begin
      prod = a_row[k*DATA_W +: DATA_W] * b_col[k*DATA_W +: DATA_W];
      sum  = sum + ACC_W'(prod);
    end
  end

  assign elem = fit_elem(sum);

endmodule

// File: rtl/matrix_mult_10x10.sv
// Sequential 10x10 matrix multiplier: writes one row of C = A x B per clock, then holds.
// Optional macro SATURATE_EN selects clamped instead of wrapped output elements.
module matrix_mult_10x10
  import matmul_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*N*DATA_W-1:0]   A,
  input  logic [N*N*DATA_W-1:0]   B,
  output logic [N*N*DATA_W-1:0]   C,
  output logic                    done
);

  localparam int ROW_W = N * DATA_W;

  state_t            state, state_nxt;
  logic [3:0]        row, row_nxt;
  logic              done_nxt;
  logic              wr_en;
  logic [ROW_W-1:0]  a_row;
  logic [ROW_W-1:0]  b_col [N];
  logic [DATA_W-1:0] elem [N];
  // Full-width column sums are kept visible for debug only.
  logic [ACC_W-1:0]  acc_unused [N];

  always_comb begin
    a_row = '0;
    for (int i = 0; i < N; i++)
      if (row == 4'(i)) a_row = A[i*ROW_W +: ROW_W];
  end

  always_comb begin
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        b_col[j][k*DATA_W +: DATA_W] = B[elem_idx(k, j) +: DATA_W];
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    dot_product_10 u_dot (
      .a_row (a_row),
      .b_col (b_col[j]),
      .sum   (acc_unused[j]),
      .elem  (elem[j])
    );
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    done_nxt  = done;
    wr_en     = 1'b0;
    case (state)
      COMPUTE: begin
        wr_en   = 1'b1;
        row_nxt = row + 4'd1;
        if (row == 4'(N - 1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          row_nxt   = row;
        end
      end
      DONE:    ;
      default: state_nxt = COMPUTE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COMPUTE;
      row   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      done  <= done_nxt;
    end
  end

  // Result register: only the currently selected row is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      C <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (row == 4'(i)) C[elem_idx(i, j) +: DATA_W] <= elem[j];
    end
  end

endmodule

// File: tb/tb_matrix_mult_10x10.sv
// Directed bench for matrix_mult_10x10 with a queue of expected result matrices.
module tb_matrix_mult_10x10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [799:0] a   = '0;
  logic [799:0] b   = '0;
  logic [799:0] c;
  logic         done;

  int total = 0;
  int bad   = 0;
  logic [799:0] sb [$];

  matrix_mult_10x10 dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .C    (c),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] el(input logic [799:0] m, input int i, input int j);
    return m[(i*10+j)*8 +: 8];
  endfunction

  // Reference product with only the first 'rows' rows filled in.
  function automatic logic [799:0] model(input logic [799:0] ma, input logic [799:0] mb,
                                         input int rows);
    logic [799:0] r;
    int s;
    r = '0;
    for (int i = 0; i < rows; i++)
      for (int j = 0; j < 10; j++) begin
        s = 0;
        for (int k = 0; k < 10; k++)
          s += int'(el(ma, i, k)) * int'(el(mb, k, j));
`ifdef SATURATE_EN
        r[(i*10+j)*8 +: 8] = (s > 255) ? 8'd255 : 8'(s);
`else
        r[(i*10+j)*8 +: 8] = 8'(s % 256);
`endif
      end
    return r;
  endfunction

  task automatic check(input string tag, input logic [799:0] obs, input logic [799:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Releases reset and waits (bounded) for done; expects it on exactly the 10th edge.
  task automatic run_full(input string tag);
    int edges;
    logic [799:0] exp;
    sb.push_back(model(a, b, 10));
    @(negedge clk);
    rst   = 1'b1;
    edges = 0;
    while (!done && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_edges"}, 800'(edges), 800'(10));
    check({tag, "_done"}, 800'(done), 800'(1));
    exp = sb.pop_front();
    check({tag, "_C"}, c, exp);
  endtask

  initial begin
    logic [799:0] exp;
    logic [799:0] held;

    // Reset state
    @(negedge clk);
    check("reset_C", c, '0);
    check("reset_done", 800'(done), 800'(0));

    // A = 1..100, B = identity -> C == A
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) begin
        a[(i*10+j)*8 +: 8] = 8'(i*10 + j + 1);
        b[(i*10+j)*8 +: 8] = (i == j) ? 8'd1 : 8'd0;
      end
    run_full("ident_b");
    check("ident_b_c00", 800'(el(c, 0, 0)), 800'(1));
    check("ident_b_c99", 800'(el(c, 9, 9)), 800'(100));

    // A = identity, B(i,j) = i+2j -> C == B
    enter_reset();
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) begin
        a[(i*10+j)*8 +: 8] = (i == j) ? 8'd1 : 8'd0;
        b[(i*10+j)*8 +: 8] = 8'(i + 2*j);
      end
    run_full("ident_a");
    check("ident_a_c99", 800'(el(c, 9, 9)), 800'(27));

    // Partial progress: all ones, three edges
    enter_reset();
    for (int n = 0; n < 100; n++) begin
      a[n*8 +: 8] = 8'd1;
      b[n*8 +: 8] = 8'd1;
    end
    sb.push_back(model(a, b, 3));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp = sb.pop_front();
    check("partial_C", c, exp);
    check("partial_c25", 800'(el(c, 2, 5)), 800'(10));
    check("partial_c30", 800'(el(c, 3, 0)), 800'(0));
    check("partial_done", 800'(done), 800'(0));

    // Overflow: all 255
    enter_reset();
    for (int n = 0; n < 100; n++) begin
      a[n*8 +: 8] = 8'd255;
      b[n*8 +: 8] = 8'd255;
    end
    run_full("ovf");
`ifdef SATURATE_EN
    check("ovf_c47", 800'(el(c, 4, 7)), 800'(255));
`else
    check("ovf_c47", 800'(el(c, 4, 7)), 800'(10));
`endif

    // Reset asserted mid-operation clears asynchronously
    enter_reset();
    for (int n = 0; n < 100; n++) begin
      a[n*8 +: 8] = 8'($urandom_range(0, 255));
      b[n*8 +: 8] = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_C", c, '0);
    check("midrst_done", 800'(done), 800'(0));
    run_full("midrst");

    // Hold: inputs change after done, result must not
    held = model(a, b, 10);
    for (int n = 0; n < 100; n++) begin
      a[n*8 +: 8] = 8'($urandom_range(0, 255));
      b[n*8 +: 8] = ~b[n*8 +: 8];
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("hold_C", c, held);
      check("hold_done", 800'(done), 800'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_mult_10x10.md
Name: matrix_mult_10x10

Overview:
- Sequential 10x10 integer matrix multiplier: C = A x B.
- A, B and C are flattened 8-bit-element buses.
- Computes one output row per clock, then asserts done and holds the result.
- Sits as a compute core behind a host/stimulus block that drives the operands statically.

Parameters:
- DATA_W, 8, element width of A, B and C.
- ACC_W, 20, internal accumulator width (16-bit product plus 4 bits of growth for 10 terms).
- N, 10, matrix dimension (localparam; not overridable).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- A  input  800  left operand; element (i,j) at bits [(i*10+j)*8 +: 8], row-major, unsigned.
- B  input  800  right operand; same packing as A.
- C  output  800  registered result; same packing; element = low DATA_W bits of the sum.
- done  output  1  high once all 10 rows are written; stays high until reset.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk and rst).
- Reset (rst=0, asynchronous): C=0, done=0, row counter=0, state=COMPUTE.
- States:
  - COMPUTE: on each rising edge with rst=1:
    - For all j, C(r,j) <= sum over k of A(r,k)*B(k,j), computed combinationally from the live A and B inputs.
    - r <= r+1.
    - When r==9, the same edge writes row 9, sets done=1 and moves to DONE.
  - DONE: C and done hold; inputs are ignored. Only reset restarts computation.
- Latency: row r is valid after the (r+1)th rising edge following reset release; full result and done are valid after the 10th edge.
- Rows not yet computed read 0.
- Arithmetic:
  - Unsigned 8x8 products, 16 bits each.
  - 10-term sum in ACC_W=20 bits, so there is no internal overflow.
  - Output element = sum mod 256 (wrap); see SATURATE_EN for the alternative.
- A and B must be stable from reset release until done. Changing them mid-computation affects only rows not yet written; this is legal and must not be flagged as an error.
- Reset asserted mid-operation: immediate clear to reset values; computation restarts from row 0 after release.
- No start input and no back-pressure. done is level, not a pulse.

Optional Feature:
- Macro SATURATE_EN.
- Defined: each output element is min(sum, 255).
- Undefined (default): each output element is sum[7:0].

Decomposition:
- Shared package matmul_pkg holds:
  - localparams N=10, DATA_W=8, ACC_W=20;
  - state typedef {COMPUTE, DONE};
  - helper function elem_idx(i,j)=(i*N+j)*DATA_W.
- One sub-module, dot_product_10: takes a 10-element row of A and a 10-element column of B and returns the ACC_W sum plus the wrapped or saturated 8-bit element. It is instantiated 10 times, one per output column.
- Row selection mux and column extraction stay in the top level.

Test Plan:
- A = 1..100 row-major, B = identity, reset released -> after 10 edges C == A (row 0 = 1..10, row 9 = 91..100) and done=1 on the 10th edge, not the 9th.
- A = identity, B(i,j) = i+2j -> C == B; check C(9,9)=27.
- Partial progress: A=B=all ones -> after 3 edges rows 0-2 are all 10, rows 3-9 are 0, done=0.
- Overflow: A=B=all 255 -> sum 650250, C elements = 10 (wrap); with SATURATE_EN, C elements = 255.
- Reset mid-operation: assert rst=0 after edge 5 -> C=0 and done=0 immediately (asynchronous); after release, the full result is correct 10 edges later.
- Hold: after done, change A and B -> C and done unchanged for 20 cycles.
